// File: rtl/sha_msg_feeder.sv
// -----------------------------------------------------------------------------
// sha_msg_feeder
//
// Initiator side of the SHA engine block interface. Accepts a message as a
// stream of big-endian 32-bit words, applies the standard SHA message padding
// (0x80 marker, zero fill, big-endian bit length), packs the result into
// 512-bit (SHA-1/224/256) or 1024-bit (SHA-384/512/512_224/512_256) blocks,
// hands them to the engine and captures the final digest.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   s_valid/s_ready message word handshake
//   s_data          four message bytes, [31:24] first
//   s_last          final word of the message
//   s_nbytes        valid bytes on the last word (0..4, left-justified)
//   s_mode          hash mode, sampled on the first word of a message
//   eng_valid/ready block handshake toward the engine
//   eng_new_msg     marks the first block of a message
//   eng_mode        mode latched for the current message
//   eng_msg         block data, byte 0 in the most significant byte used
//   eng_hash        engine digest, right-justified
//   hash            captured final digest
//   hash_valid      one-cycle pulse when hash is updated
//   busy            message in progress
// -----------------------------------------------------------------------------
module sha_msg_feeder #(
    parameter int LEN_W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [31:0]    s_data,
    input  logic           s_last,
    input  logic [2:0]     s_nbytes,
    input  logic [2:0]     s_mode,
    output logic           eng_valid,
    input  logic           eng_ready,
    output logic           eng_new_msg,
    output logic [2:0]     eng_mode,
    output logic [1023:0]  eng_msg,
    input  logic [511:0]   eng_hash,
    output logic [511:0]   hash,
    output logic           hash_valid,
    output logic           busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PAD,
        ST_SEND,
        ST_WAIT
    } state_t;

    // Block size in bytes for a mode.
    function automatic logic [7:0] blk_bytes(input logic [2:0] mode);
        return (mode >= 3'd3) ? 8'd128 : 8'd64;
    endfunction

    // Width of the trailing length field in bytes for a mode.
    function automatic logic [4:0] len_bytes(input logic [2:0] mode);
        return (mode >= 3'd3) ? 5'd16 : 5'd8;
    endfunction

    // Number of message bytes carried by the current beat.
    function automatic logic [2:0] beat_bytes(input logic last, input logic [2:0] nb);
        if (!last)
            return 3'd4;
        else if (nb > 3'd4)
            return 3'd4;
        else
            return nb;
    endfunction

    // Registered state
    state_t              r_state;
    logic [2:0]          r_mode;
    logic                r_first;
    logic                r_final;
    logic                r_pad_placed;   // 0x80 marker already written
    logic                r_pad_pending;  // message ended, length not yet written
    logic                r_wait_first;   // first WAIT cycle, engine ready is stale
    logic [7:0]          r_ptr;          // next free byte in the block
    logic [LEN_W-1:0]    r_len;          // message length in bits
    logic [127:0][7:0]   r_blk;          // r_blk[k] is byte k of the block
    logic [511:0]        r_hash;
    logic                r_hash_valid;

    // Next-state values
    state_t              w_state_nxt;
    logic [2:0]          w_mode_nxt;
    logic                w_first_nxt;
    logic                w_final_nxt;
    logic                w_pad_placed_nxt;
    logic                w_pad_pending_nxt;
    logic                w_wait_first_nxt;
    logic [7:0]          w_ptr_nxt;
    logic [LEN_W-1:0]    w_len_nxt;
    logic [127:0][7:0]   w_blk_nxt;
    logic [511:0]        w_hash_nxt;
    logic                w_hash_valid_nxt;

    // Combinational helpers
    logic [2:0]          w_mode_eff;
    logic [7:0]          w_bs;
    logic [4:0]          w_lf;
    logic [2:0]          w_nb;
    logic [5:0]          w_add;
    logic [LEN_W-1:0]    w_len_base;
    logic [127:0]        w_len_ext;
    logic [7:0]          w_ptr_a;
    logic [1023:0]       w_msg;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_mode        <= 3'd0;
            r_first       <= 1'b0;
            r_final       <= 1'b0;
            r_pad_placed  <= 1'b0;
            r_pad_pending <= 1'b0;
            r_wait_first  <= 1'b0;
            r_ptr         <= 8'd0;
            r_len         <= '0;
            r_blk         <= '0;
            r_hash        <= '0;
            r_hash_valid  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_mode        <= w_mode_nxt;
            r_first       <= w_first_nxt;
            r_final       <= w_final_nxt;
            r_pad_placed  <= w_pad_placed_nxt;
            r_pad_pending <= w_pad_pending_nxt;
            r_wait_first  <= w_wait_first_nxt;
            r_ptr         <= w_ptr_nxt;
            r_len         <= w_len_nxt;
            r_blk         <= w_blk_nxt;
            r_hash        <= w_hash_nxt;
            r_hash_valid  <= w_hash_valid_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_mode_nxt        = r_mode;
        w_first_nxt       = r_first;
        w_final_nxt       = r_final;
        w_pad_placed_nxt  = r_pad_placed;
        w_pad_pending_nxt = r_pad_pending;
        w_wait_first_nxt  = r_wait_first;
        w_ptr_nxt         = r_ptr;
        w_len_nxt         = r_len;
        w_blk_nxt         = r_blk;
        w_hash_nxt        = r_hash;
        w_hash_valid_nxt  = 1'b0;

        // In IDLE the incoming beat defines the mode; afterwards the latched one.
        w_mode_eff = (r_state == ST_IDLE) ? s_mode : r_mode;
        w_bs       = blk_bytes(w_mode_eff);
        w_lf       = len_bytes(w_mode_eff);
        w_nb       = beat_bytes(s_last, s_nbytes);
        w_add      = s_last ? {w_nb, 3'b000} : 6'd32;
        w_len_base = (r_state == ST_IDLE) ? '0 : r_len;
        w_len_ext  = 128'(r_len);
        w_ptr_a    = r_ptr;

        case (r_state)
            ST_IDLE, ST_FILL: begin
                if (s_valid) begin
                    if (r_state == ST_IDLE) begin
                        w_mode_nxt        = s_mode;
                        w_first_nxt       = 1'b1;
                        w_final_nxt       = 1'b0;
                        w_pad_placed_nxt  = 1'b0;
                        w_pad_pending_nxt = 1'b0;
                    end
                    // Non-last beats always land word-aligned inside the block.
                    for (int j = 0; j < 4; j++) begin
                        if (3'(j) < w_nb)
                            w_blk_nxt[7'(r_ptr + 8'(j))] = s_data[31-8*j -: 8];
                    end
                    w_ptr_nxt = r_ptr + {5'b00000, w_nb};
                    w_len_nxt = w_len_base + LEN_W'(w_add);
                    if (s_last) begin
                        w_pad_pending_nxt = 1'b1;
                        // A last beat that fills the block ships it unpadded;
                        // the marker then starts the next block.
                        w_state_nxt = (w_ptr_nxt == w_bs) ? ST_SEND : ST_PAD;
                    end else begin
                        w_state_nxt = (w_ptr_nxt == w_bs) ? ST_SEND : ST_FILL;
                    end
                end
            end

            ST_PAD: begin
                if (!r_pad_placed) begin
                    w_blk_nxt[r_ptr[6:0]] = 8'h80;
                    w_ptr_a               = r_ptr + 8'd1;
                end
                w_pad_placed_nxt = 1'b1;
                w_ptr_nxt        = w_ptr_a;
                // Length fits behind the marker: this is the final block.
                if ((w_bs - w_ptr_a) >= {3'b000, w_lf}) begin
                    for (int i = 0; i < 16; i++) begin
                        if (5'(i) < w_lf)
                            w_blk_nxt[7'(w_bs - 8'd1 - 8'(i))] = w_len_ext[8*i +: 8];
                    end
                    w_final_nxt       = 1'b1;
                    w_pad_pending_nxt = 1'b0;
                end
                w_state_nxt = ST_SEND;
            end

            ST_SEND: begin
                if (eng_ready) begin
                    w_first_nxt      = 1'b0;
                    w_wait_first_nxt = 1'b1;
                    w_state_nxt      = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // The engine still shows ready in the cycle after accepting.
                if (r_wait_first) begin
                    w_wait_first_nxt = 1'b0;
                end else if (eng_ready) begin
                    w_blk_nxt = '0;
                    w_ptr_nxt = 8'd0;
                    if (r_final) begin
                        w_hash_nxt        = eng_hash;
                        w_hash_valid_nxt  = 1'b1;
                        w_len_nxt         = '0;
                        w_final_nxt       = 1'b0;
                        w_first_nxt       = 1'b0;
                        w_pad_placed_nxt  = 1'b0;
                        w_pad_pending_nxt = 1'b0;
                        w_state_nxt       = ST_IDLE;
                    end else if (r_pad_pending) begin
                        w_state_nxt = ST_PAD;
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Block layout: byte k sits at eng_msg[8*(BS-k)-1 -: 8]; upper half is zero
    // in 512-bit modes.
    // -------------------------------------------------------------------------
    always_comb begin
        w_msg = '0;
        if (r_mode >= 3'd3) begin
            for (int k = 0; k < 128; k++)
                w_msg[8*(128-k)-1 -: 8] = r_blk[k];
        end else begin
            for (int k = 0; k < 64; k++)
                w_msg[8*(64-k)-1 -: 8] = r_blk[k];
        end
    end

    assign s_ready     = (r_state == ST_IDLE) || (r_state == ST_FILL);
    assign eng_valid   = (r_state == ST_SEND);
    assign eng_new_msg = (r_state == ST_SEND) && r_first;
    assign eng_mode    = r_mode;
    assign eng_msg     = w_msg;
    assign hash        = r_hash;
    assign hash_valid  = r_hash_valid;
    assign busy        = (r_state != ST_IDLE);

endmodule
